// File: rtl/bp_update_queue_if.sv
// Handshake bundle between the branch update queue, execute-stage resolution and predictor update/clear ports.
// The slave side is the queue itself; the master side is the surrounding core (or a testbench).
interface bp_update_queue_if #(
  parameter int VLEN    = 64,
  parameter int NR_ROWS = 512
);
  logic                       res_valid_i;
  logic [VLEN-1:0]            res_pc_i;
  logic                       res_taken_i;
  logic                       upd_valid_o;
  logic [VLEN-1:0]            upd_pc_o;
  logic                       upd_taken_o;
  logic                       upd_ready_i;
  logic                       clr_valid_o;
  logic [$clog2(NR_ROWS)-1:0] clr_row_o;

  modport slave (
    input  res_valid_i, res_pc_i, res_taken_i, upd_ready_i,
    output upd_valid_o, upd_pc_o, upd_taken_o, clr_valid_o, clr_row_o
  );

  modport master (
    output res_valid_i, res_pc_i, res_taken_i, upd_ready_i,
    input  upd_valid_o, upd_pc_o, upd_taken_o, clr_valid_o, clr_row_o
  );
endinterface

// File: rtl/bp_update_queue.sv
// Branch predictor update FIFO with row-by-row table clear on reset/flush; BPQ_COALESCE_EN merges same-PC tail updates.
// Enqueue-to-upd_valid_o latency 1 cycle; predictor backpressure holds the head, a full queue drops (counted), execute never stalls.
module bp_update_queue #(
  parameter int VLEN    = 64,
  parameter int DEPTH   = 4,
  parameter int NR_ROWS = 512,
  parameter int CNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_bp_i,
  input  logic                debug_mode_i,
  bp_update_queue_if.slave    bus,
  output logic                busy_o,
  output logic [CNT_W-1:0]    drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(NR_ROWS);

  typedef enum logic [1:0] {INIT_WALK, RUN, FLUSH_WALK} state_t;

  state_t            r_state;
  logic [RW-1:0]     r_row;
  logic              r_busy;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_cnt;
  logic [CNT_W-1:0]  r_drop;
  logic [VLEN-1:0]   r_pc_mem [DEPTH];
  logic              r_tk_mem [DEPTH];

  logic w_run, w_act, w_empty, w_full;
  logic w_pop, w_elig, w_coal, w_push, w_drop;

  assign w_run   = (r_state == RUN);
  assign w_act   = w_run && !flush_bp_i;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = w_act && !w_empty && bus.upd_ready_i;
  assign w_elig  = w_act && bus.res_valid_i && !debug_mode_i;

`ifdef BPQ_COALESCE_EN
  logic [AW-1:0] w_tail;
  assign w_tail = r_wr_ptr - AW'(1);
  // A lone entry leaving this cycle cannot absorb the update; it gets a fresh slot.
  assign w_coal = w_elig && !w_empty && (r_pc_mem[w_tail] == bus.res_pc_i) &&
                  !((r_cnt == CW'(1)) && w_pop);
`else
  assign w_coal = 1'b0;
`endif

  assign w_push = w_elig && !w_coal && (!w_full || w_pop);
  assign w_drop = w_elig && !w_coal && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr] <= bus.res_pc_i;
      r_tk_mem[r_wr_ptr] <= bus.res_taken_i;
    end
`ifdef BPQ_COALESCE_EN
    else if (w_coal) begin
      r_tk_mem[w_tail] <= bus.res_taken_i;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= INIT_WALK;
      r_row    <= '0;
      r_busy   <= 1'b1;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_drop   <= '0;
    end else begin
      case (r_state)
        INIT_WALK, FLUSH_WALK: begin
          if (flush_bp_i) begin
            r_row <= '0;
          end else if (r_row == RW'(NR_ROWS - 1)) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
            r_row   <= '0;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        RUN: begin
          if (flush_bp_i) begin
            r_state  <= FLUSH_WALK;
            r_busy   <= 1'b1;
            r_row    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
          end else begin
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_drop && (r_drop != {CNT_W{1'b1}})) r_drop <= r_drop + CNT_W'(1);
          end
        end
        default: begin
          r_state <= INIT_WALK;
          r_row   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.upd_valid_o = w_run && !w_empty;
  assign bus.upd_pc_o    = r_pc_mem[r_rd_ptr];
  assign bus.upd_taken_o = r_tk_mem[r_rd_ptr];
  assign bus.clr_valid_o = r_busy;
  assign bus.clr_row_o   = r_row;
  assign busy_o          = r_busy;
  assign drop_cnt_o      = r_drop;
endmodule
